iic_byte_master: RTL and testbench
==================================

IIC_BYTE_MASTER -- requirements
Module: iic_byte_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250: clk cycles per SCL quarter-period (100 MHz -> 100 kHz SCL).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h1E: 7-bit slave address (HMC5883L).
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-005 SHALL have port iicwr_req  input  1  write request, level, held until iic_ack.
REQ-006 SHALL have port iicrd_req  input  1  read request, level, held until iic_ack.
REQ-007 SHALL have port iic_addr  input  8  slave register address.
REQ-008 SHALL have port iic_wrdb  input  8  write data byte.
REQ-009 SHALL have port iic_rddb  output  8  read data byte, valid while iic_ack=1 and held until the next read completes.
REQ-010 SHALL have port iic_ack  output  1  one-cycle transaction-complete pulse.
REQ-011 SHALL have port iic_err  output  1  one-cycle pulse coincident with iic_ack when any slave ACK slot read NACK.
REQ-012 SHALL have port scl  output  1  IIC clock, push-pull.
REQ-013 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release.
REQ-014 SHALL have port sda_i  input  1  sampled SDA line level.

Function
REQ-015 SHALL time every bit as 4 quarter-periods of CLK_DIV cycles each; SCL low in Q0/Q1, high in Q2/Q3; SDA changes only at Q0 start; SDA sampled at end of Q2.
REQ-016 SHALL implement states IDLE, START, TXBYTE, RXACK, RSTART, RXBYTE, TXNACK, STOP, DONE.
REQ-017 SHALL, in IDLE when armed, latch iic_addr, iic_wrdb and the request type on the cycle a request is seen high, then enter START next cycle.
REQ-018 SHALL give iicwr_req priority when both requests are high in the same cycle.
REQ-019 SHALL sequence writes as START, {DEV_ADDR,0}, RXACK, iic_addr, RXACK, iic_wrdb, RXACK, STOP: 29 bit periods total.
REQ-020 SHALL sequence reads as START, {DEV_ADDR,0}, RXACK, iic_addr, RXACK, RSTART, {DEV_ADDR,1}, RXACK, RXBYTE, TXNACK, STOP: 39 bit periods total.
REQ-021 SHALL form START and RSTART as SDA falling while SCL high (SDA released Q0-Q1, low from Q2); STOP as SDA rising while SCL high.
REQ-022 SHALL transmit MSB first with a 3-bit bit counter; SHALL assemble RXBYTE MSB first into a shift register.
REQ-023 SHALL record a NACK (sda_i=1 at ACK sample) into a sticky error flag, continue the full sequence unchanged, and clear the flag at the next START.
REQ-024 SHALL enter DONE after STOP's last quarter, pulse iic_ack (and iic_err if flagged) for exactly one cycle, update iic_rddb on reads only, then return to IDLE disarmed.
REQ-025 SHALL re-arm only after observing iicwr_req=0 and iicrd_req=0 in the same cycle, so a request still high on the cycle after iic_ack is not restarted.
REQ-026 SHALL ignore request and data input changes while a transaction is in progress.
REQ-027 SHALL hold scl=1 and sda_oe=0 in IDLE and DONE.

Reset
REQ-028 SHALL, while rst_n=0, force scl=1, sda_oe=0, iic_ack=0, iic_err=0, iic_rddb=8'h00, state IDLE armed, all counters 0, immediately and asynchronously.
REQ-029 SHALL, on reset mid-transaction, abandon the transfer without issuing STOP and without pulsing iic_ack.

Verification (CLK_DIV=4)
REQ-030 SHALL verify write: iicwr_req, addr 8'h00, wrdb 8'h70, slave model ACKs -> SDA bytes 3C,00,70, iic_ack one pulse 464 cycles (29x16) after START entry plus 1, iic_err=0.
REQ-031 SHALL verify read: iicrd_req, addr 8'h04, slave returns 8'hA5 -> bytes 3C,04, repeated START, 3D, master NACK, STOP, iic_rddb=8'hA5 at iic_ack.
REQ-032 SHALL verify NACK: slave NACKs the device byte -> the full 29-bit write completes, iic_ack and iic_err pulse together, and the next transaction shows iic_err=0.
REQ-033 SHALL verify re-arm: iicrd_req held 3 cycles past iic_ack -> no second START until the request is seen low.
REQ-034 SHALL verify priority: iicwr_req and iicrd_req rise together -> a write sequence is issued.
REQ-035 SHALL verify reset: rst_n pulsed low during the RXBYTE of a read -> scl=1 and sda_oe=0 the same cycle, no iic_ack, and a following write completes normally.

Source files
------------

// File: rtl/iic_byte_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : iic_byte_master
// Purpose  : Single-byte IIC master. It issues one register write
//            (dev+W, reg, data) or one register read (dev+W, reg,
//            repeated START, dev+R, data, master NACK), then STOP.
//            Every bit is four quarters of CLK_DIV clk cycles.
// Ports    : clk, rst_n           - clock, async active-low reset
//            iicwr_req/iicrd_req - level requests, held until iic_ack
//            iic_addr, iic_wrdb  - register address / write byte
//            iic_rddb            - last read byte (held between reads)
//            iic_ack, iic_err    - one-cycle completion / slave-NACK pulses
//            scl, sda_oe, sda_i  - bus clock, SDA pull-low enable, SDA level
// Revision : 1.0 - initial release
// ============================================================================
module iic_byte_master #(
  parameter int         CLK_DIV  = 250,
  parameter logic [6:0] DEV_ADDR = 7'h1E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iicwr_req,
  input  logic       iicrd_req,
  input  logic [7:0] iic_addr,
  input  logic [7:0] iic_wrdb,
  output logic [7:0] iic_rddb,
  output logic       iic_ack,
  output logic       iic_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    TXBYTE = 4'd2,
    RXACK  = 4'd3,
    RSTART = 4'd4,
    RXBYTE = 4'd5,
    TXNACK = 4'd6,
    STOP   = 4'd7,
    DONE   = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;     // which transmitted byte of the frame
  logic             is_rd_q, is_rd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             err_q, err_d;       // sticky NACK flag for this transfer
  logic             armed_q, armed_d;
  logic             ack_q, ack_d;
  logic             errp_q, errp_d;
  logic [7:0]       rddb_q, rddb_d;

  logic       qtr_end;
  logic       sample;
  logic       bit_end;
  logic [7:0] tx_byte;

  assign qtr_end = (div_q == DIV_LAST);
  assign sample  = qtr_end && (qtr_q == 2'd2);
  assign bit_end = qtr_end && (qtr_q == 2'd3);

  always_comb begin
    case (byte_q)
      2'd0:    tx_byte = {DEV_ADDR, 1'b0};
      2'd1:    tx_byte = addr_q;
      default: tx_byte = is_rd_q ? {DEV_ADDR, 1'b1} : wdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      is_rd_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      shreg_q <= 8'h00;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      ack_q   <= 1'b0;
      errp_q  <= 1'b0;
      rddb_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      errp_q  <= errp_d;
      rddb_q  <= rddb_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    qtr_d   = 2'd0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    shreg_d = shreg_q;
    err_d   = err_q;
    armed_d = armed_q;
    ack_d   = 1'b0;
    errp_d  = 1'b0;
    rddb_d  = rddb_q;

    // Quarter/bit timebase runs only while a transfer is on the bus; it wraps
    // to zero exactly on bit_end, so each new state starts at Q0.
    if (state_q != IDLE && state_q != DONE) begin
      div_d = qtr_end ? '0 : div_q + DIV_W'(1);
      qtr_d = qtr_end ? qtr_q + 2'd1 : qtr_q;
    end

    case (state_q)
      IDLE: begin
        if (!armed_q) begin
          if (!iicwr_req && !iicrd_req) armed_d = 1'b1;
        end else if (iicwr_req || iicrd_req) begin
          is_rd_d = !iicwr_req;           // write wins when both are high
          addr_d  = iic_addr;
          wdata_d = iic_wrdb;
          err_d   = 1'b0;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = TXBYTE;
        byte_d  = 2'd0;
        bit_d   = 3'd7;
      end
      TXBYTE: if (bit_end) begin
        if (bit_q == 3'd0) state_d = RXACK;
        else               bit_d   = bit_q - 3'd1;
      end
      RXACK: begin
        if (sample && sda_i) err_d = 1'b1;
        if (bit_end) begin
          bit_d = 3'd7;
          case (byte_q)
            2'd0: begin
              byte_d  = 2'd1;
              state_d = TXBYTE;
            end
            2'd1: begin
              byte_d  = 2'd2;
              state_d = is_rd_q ? RSTART : TXBYTE;
            end
            default: state_d = is_rd_q ? RXBYTE : STOP;
          endcase
        end
      end
      RSTART: if (bit_end) begin
        state_d = TXBYTE;
        bit_d   = 3'd7;
      end
      RXBYTE: begin
        if (sample) shreg_d = {shreg_q[6:0], sda_i};
        if (bit_end) begin
          if (bit_q == 3'd0) state_d = TXNACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      TXNACK: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = DONE;
      DONE: begin
        ack_d   = 1'b1;
        errp_d  = err_q;
        if (is_rd_q) rddb_d = shreg_q;
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus drive. START/RSTART/STOP raise SCL one quarter early (Q1) so that the
  // SDA edge at Q2 lands while SCL is already stable high.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      START, RSTART: begin
        scl    = (qtr_q != 2'd0);
        sda_oe = qtr_q[1];
      end
      STOP: begin
        scl    = (qtr_q != 2'd0);
        sda_oe = !qtr_q[1];
      end
      TXBYTE: begin
        scl    = qtr_q[1];
        sda_oe = !tx_byte[bit_q];
      end
      RXACK, RXBYTE, TXNACK: scl = qtr_q[1];
      default: begin
        scl    = 1'b1;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign iic_ack  = ack_q;
  assign iic_err  = errp_q;
  assign iic_rddb = rddb_q;

endmodule
`default_nettype wire

// File: tb/tb_iic_byte_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_iic_byte_master
// Purpose  : Directed bench for iic_byte_master (CLK_DIV=4). A bus-level slave
//            model decodes START/STOP/bytes and answers ACK/data; expected
//            transaction records are queued by the stimulus and compared by
//            the monitor at each iic_ack pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_byte_master;

  localparam logic [7:0] DEV_W = 8'h3C;
  localparam logic [7:0] DEV_R = 8'h3D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iicwr_req = 1'b0;
  logic       iicrd_req = 1'b0;
  logic [7:0] iic_addr = 8'h00;
  logic [7:0] iic_wrdb = 8'h00;
  logic [7:0] iic_rddb;
  logic       iic_ack, iic_err, scl, sda_oe;
  logic       sda_line;
  logic       slv_pull = 1'b0;

  assign sda_line = ~(sda_oe | slv_pull);

  iic_byte_master #(.CLK_DIV(4), .DEV_ADDR(7'h1E)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iicwr_req (iicwr_req),
    .iicrd_req (iicrd_req),
    .iic_addr  (iic_addr),
    .iic_wrdb  (iic_wrdb),
    .iic_rddb  (iic_rddb),
    .iic_ack   (iic_ack),
    .iic_err   (iic_err),
    .scl       (scl),
    .sda_oe    (sda_oe),
    .sda_i     (sda_line)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    logic        err;
    int          starts;
    logic        is_rd;
    logic [7:0]  rddb;
    int          lat;
  } exp_t;
  exp_t expq[$];

  // Slave configuration
  logic       slv_nack_dev = 1'b0;
  logic [7:0] slv_rdata = 8'h00;

  // Slave / decoder state
  logic        prev_scl = 1'b1, prev_sda = 1'b1;
  logic        in_txn = 1'b0, in_frame = 1'b0, s_tx = 1'b0, rw = 1'b0;
  int          s_bitc = 0, bidx = 0, nb = 0, starts = 0, t0 = 0;
  logic [7:0]  sh = 8'h00;
  logic [31:0] blog = 32'h0;
  logic        mnack = 1'b0, stop_seen = 1'b0;

  // Monitor: bus decode, slave response and scoreboard compare
  always @(negedge clk) begin
    logic sc, sd;
    exp_t e;
    if (!rst_n) begin
      prev_scl = 1'b1; prev_sda = 1'b1; in_txn = 1'b0; in_frame = 1'b0;
      s_tx = 1'b0; s_bitc = 0; slv_pull = 1'b0;
    end else begin
      sc = scl;
      sd = sda_line;
      if (prev_scl && !sc && !in_txn) begin
        in_txn = 1'b1; t0 = cyc; nb = 0; blog = 32'h0; starts = 0;
        mnack = 1'b0; stop_seen = 1'b0;
      end
      if (prev_scl && sc && prev_sda && !sd) begin
        in_frame = 1'b1; s_bitc = 0; bidx = 0; s_tx = 1'b0; starts++;
      end else if (prev_scl && sc && !prev_sda && sd) begin
        in_frame = 1'b0; s_tx = 1'b0; stop_seen = 1'b1; slv_pull = 1'b0;
      end else if (!prev_scl && sc && in_frame) begin
        if (s_bitc < 8) begin
          sh = {sh[6:0], sd};
          s_bitc++;
          if (s_bitc == 8) begin
            blog = {blog[23:0], sh};
            nb++;
            if (bidx == 0) rw = sh[0];
          end
        end else begin
          if (s_tx) begin
            if (sd) begin mnack = 1'b1; s_tx = 1'b0; end
          end else if (bidx == 0 && rw) begin
            s_tx = 1'b1;
          end
          bidx++;
          s_bitc = 0;
        end
      end else if (prev_scl && !sc && in_frame) begin
        if (s_bitc == 8 && !s_tx)  slv_pull = !(bidx == 0 && slv_nack_dev);
        else if (s_tx && s_bitc < 8) slv_pull = ~slv_rdata[7 - s_bitc];
        else                       slv_pull = 1'b0;
      end
      prev_scl = sc;
      prev_sda = sd;

      if (iic_ack) begin
        if (expq.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("bytes",   blog, e.bytes);
          chk("nbytes",  nb, e.nb);
          chk("err",     iic_err, e.err);
          chk("starts",  starts, e.starts);
          chk("stop",    stop_seen, 1);
          chk("latency", cyc - t0, e.lat);
          if (e.is_rd) begin
            chk("rddb",  iic_rddb, e.rddb);
            chk("mnack", mnack, 1);
          end
        end
        in_txn = 1'b0;
      end
    end
  end

  task automatic run_txn(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [7:0] wdb, input logic nack,
                         input logic [7:0] rdat, input int hold_after);
    exp_t e;
    logic is_rd, got, restarted;
    is_rd    = !wr && rd;
    e.is_rd  = is_rd;
    e.bytes  = is_rd ? {DEV_W, addr, DEV_R, rdat} : {8'h00, DEV_W, addr, wdb};
    e.nb     = is_rd ? 4 : 3;
    e.err    = nack;
    e.starts = is_rd ? 2 : 1;
    e.rddb   = rdat;
    e.lat    = is_rd ? 625 : 465;
    slv_nack_dev = nack;
    slv_rdata    = rdat;
    expq.push_back(e);
    @(negedge clk);
    iic_addr = addr; iic_wrdb = wdb; iicwr_req = wr; iicrd_req = rd;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (i == 50) begin iic_addr = ~addr; iic_wrdb = ~wdb; end
      if (iic_ack) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    restarted = 1'b0;
    for (int j = 0; j < hold_after + 20; j++) begin
      if (j == hold_after) begin iicwr_req = 1'b0; iicrd_req = 1'b0; end
      @(negedge clk);
      if (!scl || iic_ack) restarted = 1'b1;
    end
    chk("no_restart", restarted, 0);
  endtask

  initial begin
    logic found;
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    repeat (3) @(negedge clk);
    chk("rst_ack", iic_ack, 0);
    chk("rst_err", iic_err, 0);
    chk("rst_rddb", iic_rddb, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(1'b1, 1'b0, 8'h00, 8'h70, 1'b0, 8'h00, 0);   // basic write
    run_txn(1'b0, 1'b1, 8'h04, 8'h00, 1'b0, 8'hA5, 0);   // basic read
    run_txn(1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 8'h00, 0);   // device NACK
    run_txn(1'b1, 1'b0, 8'h01, 8'h5A, 1'b0, 8'h00, 0);   // error cleared
    chk("rddb_held", iic_rddb, 8'hA5);
    run_txn(1'b0, 1'b1, 8'h06, 8'h00, 1'b0, 8'h3C, 3);   // request held past ack
    run_txn(1'b1, 1'b1, 8'h07, 8'hC3, 1'b0, 8'h96, 0);   // both requests: write

    // Reset during RXBYTE of a read
    slv_nack_dev = 1'b0;
    slv_rdata    = 8'h81;
    @(negedge clk);
    iic_addr = 8'h08; iicrd_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (s_tx && s_bitc == 3 && !scl) found = 1'b1;
    end
    chk("rxbyte_reached", found, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_scl", scl, 1);
    chk("midrst_sda_oe", sda_oe, 0);
    iicrd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_ack", iic_ack, 0);
    chk("midrst_rddb", iic_rddb, 8'h00);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    run_txn(1'b1, 1'b0, 8'h0A, 8'h55, 1'b0, 8'h00, 0);
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
